// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with synchronous flush, programmable
// reset value and an optional two-entry skid buffer that registers the backpressure path.

module pipe_stage_reg_chk #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             main_valid,
    input  logic             skid_valid
);
    // A skid entry without a head entry would break FIFO order
    a_no_orphan_skid: assert property (@(posedge clk) disable iff (rst)
        !(skid_valid && !main_valid))
        else $error("pipe_stage_reg: skid entry held while head entry is empty");

    // Upstream must hold an unaccepted offer steady until it is taken
    a_in_hold: assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_data)))
        else $error("pipe_stage_reg: in_valid/in_data changed before acceptance");
endmodule

module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter bit               SKID      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);
    logic             main_valid_q;
    logic             main_valid_d;
    logic [WIDTH-1:0] main_data_q;
    logic [WIDTH-1:0] main_data_d;
    logic             skid_valid_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             pop_s;

    // Handshake qualifiers, both taken on the same edge
    always_comb begin
        accept_s = in_valid & in_ready_s;
        pop_s    = main_valid_q & out_ready;
    end

    // Head-entry state register
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= RESET_VAL;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic             skid_valid_q;
            logic             skid_valid_d;
            logic [WIDTH-1:0] skid_data_q;
            logic [WIDTH-1:0] skid_data_d;

            // Skid-entry state register
            always_ff @(posedge clk) begin
                if (rst) begin
                    skid_valid_q <= 1'b0;
                    skid_data_q  <= RESET_VAL;
                end else begin
                    skid_valid_q <= skid_valid_d;
                    skid_data_q  <= skid_data_d;
                end
            end

            // Next-state for the (main_valid, skid_valid) pair; flush beats everything
            always_comb begin
                main_valid_d = main_valid_q;
                main_data_d  = main_data_q;
                skid_valid_d = skid_valid_q;
                skid_data_d  = skid_data_q;
                if (flush) begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                    main_data_d  = RESET_VAL;
                    skid_data_d  = RESET_VAL;
                end else begin
                    case ({main_valid_q, skid_valid_q})
                        2'b00: begin
                            if (accept_s) begin
                                main_valid_d = 1'b1;
                                main_data_d  = in_data;
                            end else begin
                                main_valid_d = 1'b0;
                            end
                        end
                        2'b10: begin
                            if (accept_s && pop_s) begin
                                main_data_d = in_data;
                            end else if (accept_s) begin
                                skid_valid_d = 1'b1;
                                skid_data_d  = in_data;
                            end else if (pop_s) begin
                                main_valid_d = 1'b0;
                            end else begin
                                main_valid_d = 1'b1;
                            end
                        end
                        2'b11: begin
                            if (pop_s) begin
                                skid_valid_d = 1'b0;
                                main_data_d  = skid_data_q;
                            end else begin
                                skid_valid_d = 1'b1;
                            end
                        end
                        default: begin
                            // Orphan skid entry: recover to empty rather than emit it
                            main_valid_d = 1'b0;
                            skid_valid_d = 1'b0;
                        end
                    endcase
                end
            end

            assign in_ready_s   = ~skid_valid_q;
            assign skid_valid_s = skid_valid_q;
        end else begin : g_single
            // Next-state for the single-entry register
            always_comb begin
                main_valid_d = main_valid_q;
                main_data_d  = main_data_q;
                if (flush) begin
                    main_valid_d = 1'b0;
                    main_data_d  = RESET_VAL;
                end else if (accept_s) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data;
                end else if (pop_s) begin
                    main_valid_d = 1'b0;
                end else begin
                    main_valid_d = main_valid_q;
                end
            end

            assign in_ready_s   = ~main_valid_q | out_ready;
            assign skid_valid_s = 1'b0;
        end
    endgenerate

    // Output decode
    always_comb begin
        in_ready  = in_ready_s;
        out_valid = main_valid_q;
        out_data  = main_data_q;
        occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_s};
    end

    pipe_stage_reg_chk #(.WIDTH(WIDTH)) u_chk (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready_s),
        .in_data    (in_data),
        .main_valid (main_valid_q),
        .skid_valid (skid_valid_s)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector tables on two WIDTH=32 instances plus
// randomized traffic on four instances (8/64 bits, both modes) against a queue model.
module tb_pipe_stage_reg;
    localparam logic [31:0] RV = 32'h0040_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        chk;
        logic        chk_data;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
    } vec_t;

    // directed instances: s1 = SKID 1, s0 = SKID 0
    logic        s1_rst, s1_flush, s1_iv, s1_or, s1_ir, s1_ov;
    logic [31:0] s1_id, s1_od;
    logic [1:0]  s1_occ;
    logic        s0_rst, s0_flush, s0_iv, s0_or, s0_ir, s0_ov;
    logic [31:0] s0_id, s0_od;
    logic [1:0]  s0_occ;

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RV), .SKID(1'b1)) u_s1 (
        .clk(clk), .rst(s1_rst), .flush(s1_flush), .in_valid(s1_iv), .in_ready(s1_ir),
        .in_data(s1_id), .out_valid(s1_ov), .out_ready(s1_or), .out_data(s1_od),
        .occupancy(s1_occ));

    pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RV), .SKID(1'b0)) u_s0 (
        .clk(clk), .rst(s0_rst), .flush(s0_flush), .in_valid(s0_iv), .in_ready(s0_ir),
        .in_data(s0_id), .out_valid(s0_ov), .out_ready(s0_or), .out_data(s0_od),
        .occupancy(s0_occ));

    // random instances: 0 = W8/SKID1, 1 = W8/SKID0, 2 = W64/SKID1, 3 = W64/SKID0
    logic        r_rst;
    logic [3:0]  r_flush, r_iv, r_or, r_ir, r_ov;
    logic [7:0]  r_occ;
    logic [63:0] r_id [4];
    logic [7:0]  r_od0, r_od1;
    logic [63:0] r_od2, r_od3;

    pipe_stage_reg #(.WIDTH(8), .RESET_VAL(8'h5A), .SKID(1'b1)) u_r0 (
        .clk(clk), .rst(r_rst), .flush(r_flush[0]), .in_valid(r_iv[0]), .in_ready(r_ir[0]),
        .in_data(r_id[0][7:0]), .out_valid(r_ov[0]), .out_ready(r_or[0]), .out_data(r_od0),
        .occupancy(r_occ[1:0]));
    pipe_stage_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .SKID(1'b0)) u_r1 (
        .clk(clk), .rst(r_rst), .flush(r_flush[1]), .in_valid(r_iv[1]), .in_ready(r_ir[1]),
        .in_data(r_id[1][7:0]), .out_valid(r_ov[1]), .out_ready(r_or[1]), .out_data(r_od1),
        .occupancy(r_occ[3:2]));
    pipe_stage_reg #(.WIDTH(64), .RESET_VAL(64'h0123_4567_89AB_CDEF), .SKID(1'b1)) u_r2 (
        .clk(clk), .rst(r_rst), .flush(r_flush[2]), .in_valid(r_iv[2]), .in_ready(r_ir[2]),
        .in_data(r_id[2]), .out_valid(r_ov[2]), .out_ready(r_or[2]), .out_data(r_od2),
        .occupancy(r_occ[5:4]));
    pipe_stage_reg #(.WIDTH(64), .RESET_VAL(64'h0), .SKID(1'b0)) u_r3 (
        .clk(clk), .rst(r_rst), .flush(r_flush[3]), .in_valid(r_iv[3]), .in_ready(r_ir[3]),
        .in_data(r_id[3]), .out_valid(r_ov[3]), .out_ready(r_or[3]), .out_data(r_od3),
        .occupancy(r_occ[7:6]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic flush, input logic iv,
                                input logic [31:0] id, input logic ordy, input logic c,
                                input logic cd, input logic e_ir, input logic e_ov,
                                input logic [31:0] e_od, input logic [1:0] e_occ);
        vec_t v;
        v = '{rst, flush, iv, id, ordy, c, cd, e_ir, e_ov, e_od, e_occ};
        return v;
    endfunction

    // Drive one row on the selected directed instance, then compare before the next edge.
    task automatic apply(input int sel, input vec_t v, input int row);
        logic        ir, ov;
        logic [31:0] od;
        logic [1:0]  occ;
        string       tag;
        if (sel == 0) begin
            s1_rst = v.rst; s1_flush = v.flush; s1_iv = v.iv; s1_id = v.id; s1_or = v.ordy;
        end else begin
            s0_rst = v.rst; s0_flush = v.flush; s0_iv = v.iv; s0_id = v.id; s0_or = v.ordy;
        end
        #1;
        if (sel == 0) begin
            ir = s1_ir; ov = s1_ov; od = s1_od; occ = s1_occ;
        end else begin
            ir = s0_ir; ov = s0_ov; od = s0_od; occ = s0_occ;
        end
        tag = $sformatf("skid%0d_row%0d", 1 - sel, row);
        if (v.chk) begin
            chk({tag, "_in_ready"},  64'(ir),  64'(v.e_ir));
            chk({tag, "_out_valid"}, 64'(ov),  64'(v.e_ov));
            chk({tag, "_occupancy"}, 64'(occ), 64'(v.e_occ));
        end
        if (v.chk_data) chk({tag, "_out_data"}, 64'(od), 64'(v.e_od));
    endtask

    function automatic logic [63:0] msk(input int i);
        return (i < 2) ? 64'h0000_0000_0000_00FF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] r_od(input int i);
        case (i)
            0:       return 64'(r_od0);
            1:       return 64'(r_od1);
            2:       return r_od2;
            default: return r_od3;
        endcase
    endfunction

    vec_t        t1 [20];
    vec_t        t0 [11];
    logic [63:0] mq [4][$];
    logic [3:0]  pend, acc, pop;

    initial begin
        // SKID=1: reset, streaming, backpressure, flush priority
        t1[0]  = mk(1,0,1,32'hDEADBEEF,0, 0,0, 0,0,32'h0,0);
        t1[1]  = mk(1,0,1,32'hDEADBEEF,0, 1,1, 1,0,RV,0);
        t1[2]  = mk(1,0,1,32'hDEADBEEF,0, 1,1, 1,0,RV,0);
        t1[3]  = mk(0,0,0,32'h0,0,        1,1, 1,0,RV,0);
        t1[4]  = mk(0,0,1,32'h1,1,        1,0, 1,0,32'h0,0);
        t1[5]  = mk(0,0,1,32'h2,1,        1,1, 1,1,32'h1,1);
        t1[6]  = mk(0,0,1,32'h3,1,        1,1, 1,1,32'h2,1);
        t1[7]  = mk(0,0,1,32'h4,1,        1,1, 1,1,32'h3,1);
        t1[8]  = mk(0,0,0,32'h0,1,        1,1, 1,1,32'h4,1);
        t1[9]  = mk(0,0,1,32'hA,0,        1,0, 1,0,32'h0,0);
        t1[10] = mk(0,0,1,32'hB,0,        1,1, 1,1,32'hA,1);
        t1[11] = mk(0,0,1,32'hC,0,        1,1, 0,1,32'hA,2);
        t1[12] = mk(0,0,1,32'hC,1,        1,1, 0,1,32'hA,2);
        t1[13] = mk(0,0,1,32'hC,1,        1,1, 1,1,32'hB,1);
        t1[14] = mk(0,0,0,32'h0,1,        1,1, 1,1,32'hC,1);
        t1[15] = mk(0,0,1,32'h11,0,       1,0, 1,0,32'h0,0);
        t1[16] = mk(0,0,1,32'h22,0,       1,1, 1,1,32'h11,1);
        t1[17] = mk(0,1,1,32'h33,1,       1,1, 0,1,32'h11,2);
        t1[18] = mk(0,0,0,32'h0,1,        1,1, 1,0,RV,0);
        t1[19] = mk(0,0,0,32'h0,1,        1,1, 1,0,RV,0);
        // SKID=0: combinational ready, replace-in-place, flush on empty
        t0[0]  = mk(1,0,0,32'h0,0,        0,0, 0,0,32'h0,0);
        t0[1]  = mk(0,0,0,32'h0,0,        1,1, 1,0,RV,0);
        t0[2]  = mk(0,0,1,32'h55,0,       1,0, 1,0,32'h0,0);
        t0[3]  = mk(0,0,1,32'h66,1,       1,1, 1,1,32'h55,1);
        t0[4]  = mk(0,0,0,32'h0,0,        1,1, 0,1,32'h66,1);
        t0[5]  = mk(0,0,1,32'h77,0,       1,1, 0,1,32'h66,1);
        t0[6]  = mk(0,0,1,32'h77,1,       1,1, 1,1,32'h66,1);
        t0[7]  = mk(0,0,0,32'h0,1,        1,1, 1,1,32'h77,1);
        t0[8]  = mk(0,0,0,32'h0,0,        1,0, 1,0,32'h0,0);
        t0[9]  = mk(0,1,1,32'h88,0,       1,0, 1,0,32'h0,0);
        t0[10] = mk(0,0,0,32'h0,0,        1,1, 1,0,RV,0);

        s1_rst = 1; s1_flush = 0; s1_iv = 0; s1_id = 0; s1_or = 0;
        s0_rst = 1; s0_flush = 0; s0_iv = 0; s0_id = 0; s0_or = 0;
        r_rst = 1; r_flush = '0; r_iv = '0; r_or = '0; pend = '0;
        for (int i = 0; i < 4; i++) r_id[i] = '0;

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            apply(0, t1[k], k);
        end
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            apply(1, t0[k], k);
        end

        // Random phase: release reset with all model queues empty
        @(negedge clk);
        r_rst = 0;
        for (int c = 0; c < 10000; c++) begin
            if (c > 0) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!pend[i]) begin
                    r_iv[i] = ($urandom_range(0, 99) < 60);
                    r_id[i] = {$urandom, $urandom} & msk(i);
                end
                r_flush[i] = ($urandom_range(0, 99) < 5);
                r_or[i]    = ($urandom_range(0, 99) < 70);
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                int   sz;
                logic eir;
                sz  = mq[i].size();
                eir = (i % 2 == 0) ? (sz < 2) : (sz == 0 || r_or[i]);
                chk($sformatf("rnd%0d_in_ready", i),  64'(r_ir[i]), 64'(eir));
                chk($sformatf("rnd%0d_out_valid", i), 64'(r_ov[i]), 64'(sz > 0));
                chk($sformatf("rnd%0d_occupancy", i), 64'(r_occ[2*i +: 2]), 64'(sz));
                if (sz > 0) chk($sformatf("rnd%0d_out_data", i), r_od(i), mq[i][0]);
                acc[i] = r_iv[i] & eir;
                pop[i] = (sz > 0) & r_or[i];
            end
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                if (r_flush[i]) begin
                    mq[i].delete();
                    pend[i] = 1'b0;
                end else begin
                    if (pop[i]) void'(mq[i].pop_front());
                    if (acc[i]) mq[i].push_back(r_id[i]);
                    pend[i] = r_iv[i] & ~acc[i];
                end
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register: the successor to the plain enable/reset flop used between CPU pipeline stages.
- Adds a valid/ready handshake, synchronous flush for branch/exception squash, and a programmable reset value.
- Optional 2-entry skid buffer (SKID=1) registers the backpressure path so in_ready has no combinational dependency on out_ready.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and between the CPU core and its bus interfaces.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- RESET_VAL, 0, value loaded into the data registers on rst/flush (WIDTH bits).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single-entry register with combinational in_ready.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash; discards all held entries.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  head-entry payload.
- occupancy  output  2  number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- Single clock domain. All state updates on posedge clk. Reset is synchronous and active-high; there is no asynchronous path.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready. Both are evaluated on the same edge.
- Latency: an entry accepted at edge N appears on out_valid/out_data after edge N (1 cycle). With an empty stage and out_ready=1, sustained throughput is 1 entry/cycle in both modes.
- rst=1: main_valid=0, skid_valid=0, main_data=skid_data=RESET_VAL.
  - Resulting outputs: out_valid=0, out_data=RESET_VAL, occupancy=0.
  - in_ready: 1 when SKID=1 (registered !skid_valid); 1 when SKID=0 (!out_valid).
- flush=1 (rst=0): same state update as rst. Flush has priority over any accept or pop in that cycle. The input offered that cycle is dropped, and the pop is not counted by the downstream.
- Data registers load only on accept (or rst/flush). They hold their value when idle. out_data after a pop that leaves the stage empty is don't-care for verification; only check it while out_valid=1.
- SKID=1 state, (main_valid, skid_valid):
  - EMPTY (0,0) + accept -> ONE, main<=in.
  - ONE (1,0):
    - accept & pop -> ONE, main<=in.
    - accept & !pop -> FULL, skid<=in.
    - pop & !accept -> EMPTY.
    - neither -> hold.
  - FULL (1,1): in_ready=0, so no accept. Pop -> ONE, main<=skid.
  - (0,1) is unreachable; an assertion must flag it.
- SKID=1 in_ready = !skid_valid, taken straight from a flop. No combinational path from out_ready to in_ready.
- SKID=0: in_ready = !main_valid | out_ready (combinational). Skid register is not instantiated.
  - accept -> main<=in, main_valid=1.
  - pop & !accept -> main_valid=0.
- occupancy = main_valid + skid_valid.
- Ordering: strict FIFO, no entry dropped or duplicated except on flush/rst.
- in_data is sampled only on accept; in_data is ignored when in_valid=0.
- Protocol assumption checked by assertion: once in_valid=1, upstream holds in_valid and in_data until accepted (flush cycle excepted).

Test Plan:
1. Reset: hold rst=1 3 cycles with in_valid=1, in_data=0xDEADBEEF, RESET_VAL=0x00400000 -> out_valid=0, occupancy=0, out_data=0x00400000, in_ready=1 the cycle after rst falls.
2. Streaming, SKID=1, out_ready=1: push 0x1,0x2,0x3,0x4 on consecutive cycles -> out_data 0x1..0x4 on the 4 cycles after each accept, in_ready stays 1, occupancy stays 1.
3. Backpressure, SKID=1: out_ready=0, push 0xA,0xB,0xC -> 0xA,0xB accepted, occupancy=2, in_ready=0 so 0xC is held upstream. Then out_ready=1 -> pops 0xA,0xB,0xC in order, 1 per cycle.
4. Flush priority: FULL with 0x11,0x22, in_valid=1, in_data=0x33, out_ready=1, flush=1 -> next cycle occupancy=0, out_valid=0, 0x33 never appears on the output.
5. SKID=0 comb ready: stage holds 0x55, out_ready=1, in_valid=1 with 0x66 -> in_ready=1 in the same cycle, 0x55 popped, out_data=0x66 next cycle. With out_ready=0 -> in_ready=0.
6. Random: 10k cycles with random in_valid/out_ready/flush (5%), WIDTH=8 and WIDTH=64, both SKID modes -> scoreboard shows FIFO order, no loss except on flush, and the (0,1) state never occurs.
